my_pc_stack: RTL

- Parametrised program counter with a hardware return-address stack.
- Extends the load/inc/clear counter with call and return operations, configurable width and stack depth, and registered status flags.
- Sits at the front of the CPU fetch path, driving the instruction-memory address; the control decoder drives load/call/ret.

---
 rtl/my_pc_stack.sv | 65 ++++++
 1 files changed

// File: rtl/my_pc_stack.sv
// my_pc_stack: program counter with a hardware return-address stack and registered status flags.
// Defining MY_PC_STACK_WRAP_EN makes a call on a full stack overwrite the oldest entry instead of faulting.
module my_pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       clear,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
`ifdef MY_PC_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [WIDTH-1:0] stk [DEPTH];
  logic [AW-1:0]    ptr, ptr_dec, ptr_nxt;
  logic [WIDTH-1:0] pc_inc, out_nxt;
  logic [DW-1:0]    depth_nxt;
  logic             pop, under, do_call, push, push_full, err_nxt;
  // ptr is the write slot; it tracks depth modulo DEPTH, and keeps rotating once a full stack wraps
  always_comb begin
    pc_inc    = out + WIDTH'(1);
    ptr_dec   = ptr - AW'(1);
    pop       = ~clear & ret & ~empty;
    under     = ~clear & ret & empty;
    do_call   = ~clear & ~ret & call;
    push      = do_call & (~full | WRAP);
    push_full = do_call & full;
    out_nxt   = clear ? '0 : pop ? stk[ptr_dec] : under ? out : (do_call | load) ? in : inc ? pc_inc : out;
    depth_nxt = clear ? '0 : pop ? depth - DW'(1) : (do_call & ~full) ? depth + DW'(1) : depth;
    ptr_nxt   = clear ? '0 : pop ? ptr_dec : push ? ptr + AW'(1) : ptr;
    err_nxt   = clear ? 1'b0 : err | under | (push_full & ~WRAP);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out   <= '0;
      depth <= '0;
      ptr   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      out   <= out_nxt;
      depth <= depth_nxt;
      ptr   <= ptr_nxt;
      empty <= depth_nxt == '0;
      full  <= depth_nxt == DW'(DEPTH);
      err   <= err_nxt;
    end
  always_ff @(posedge clk)
    if (push) stk[ptr] <= pc_inc;
endmodule
